// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receive path: synchroniser, clock glitch filter, frame FSM with timeout,
// make/break/extended assembler and a first-word-fall-through event FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scan_fifo #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TIMEOUT    = 50000,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ps2d_i,
    input  logic          ps2c_i,
    input  logic          rx_en_i,
    input  logic          rd_en_i,
    input  logic          clr_err_i,
    output logic [9:0]    dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o,
    output logic          frame_err_o
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]            ps2c_sync_q, ps2d_sync_q;
    logic                  ps2c_s, ps2d_s;
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic                  filt_q, filt_d, fall;
    state_e                state_q, state_d;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            data_q;
    logic [TW-1:0]         to_cnt_q;
    logic                  timeout, parity_ok, byte_ok, frame_bad;
    logic                  byte_rdy_q, ext_q, ext_d, brk_q, brk_d, push, pop;
    logic [9:0]            mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d, frame_err_q, frame_err_d;

    assign ps2c_s = ps2c_sync_q[1];
    assign ps2d_s = ps2d_sync_q[1];

    // Lines idle high, so sync and filter reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ps2c_sync_q <= 2'b11;
            ps2d_sync_q <= 2'b11;
            filt_sr_q   <= '1;
            filt_q      <= 1'b1;
        end else begin
            ps2c_sync_q <= {ps2c_sync_q[0], ps2c_i};
            ps2d_sync_q <= {ps2d_sync_q[0], ps2d_i};
            filt_sr_q   <= {filt_sr_q[FILTER_LEN-2:0], ps2c_s};
            filt_q      <= filt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        if (&filt_sr_q) begin
            filt_d = 1'b1;
        end else if (~|filt_sr_q) begin
            filt_d = 1'b0;
        end
    end

    assign fall    = filt_q & ~filt_d;
    assign timeout = (state_q != StIdle) && (to_cnt_q == TW'(TIMEOUT));

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= 1'b0;
        end else if (fall && state_q == StParity) begin
            par_q <= ps2d_s;
        end
    end
    assign parity_ok = ^{data_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (fall) begin
            unique case (state_q)
                StIdle:   if (rx_en_i && !ps2d_s) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        byte_ok   = 1'b0;
        frame_bad = 1'b0;
        if (timeout) begin
            frame_bad = 1'b1;
        end else if (fall && state_q == StStop) begin
            byte_ok   = ps2d_s & parity_ok;
            frame_bad = ~(ps2d_s & parity_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q  <= '0;
            data_q     <= '0;
            to_cnt_q   <= '0;
            byte_rdy_q <= 1'b0;
        end else begin
            byte_rdy_q <= byte_ok;
            if (state_q == StIdle) begin
                bit_cnt_q <= '0;
            end else if (fall && state_q == StData) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                data_q    <= {ps2d_s, data_q[7:1]};
            end
            if (state_q == StIdle || fall) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TW'(TIMEOUT)) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    // Prefix bytes only arm flags; any other byte emits an event and consumes them.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (byte_rdy_q) begin
            if (data_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (data_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    assign pop     = rd_en_i & ~empty_o;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !full_o && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end
        if (push && full_o && !pop) overflow_d = 1'b1;
        if (frame_bad) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            if (push && (!full_o || pop)) begin
                mem_q[wr_ptr_q] <= {ext_q, brk_q, data_q};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
endmodule
